fp_mul_norm_round: RTL and testbench
====================================

Name: fp_mul_norm_round

Overview:
- Downstream stage of the single-precision Booth radix-4 multiplier core.
- Consumes the 48-bit raw significand product, the biased exponent sum, the result sign and special-case flags from the multiplier.
- Normalizes, rounds per r_mode, and detects overflow, underflow and inexact.
- Emits the final fp_Z through a 2-stage valid/ready pipeline.
- Subnormal results are flushed to signed zero, matching the multiplier's flush-to-zero policy on subnormal inputs.

Parameters:
- EXP_W, 10, width of the signed exponent-sum input (two's complement; must cover -126..381).
- QNAN, 32'h7FC00000, canonical NaN pattern driven for NaN results.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  upstream product valid.
- in_ready  out  1  stage can accept an input this cycle.
- in_sign  in  1  fp_X[31]^fp_Y[31].
- in_exp  in  EXP_W  signed eX+eY-127.
- in_frc  in  48  frc_Z_full, the product of {1,frc_X} and {1,frc_Y}.
- in_rmode  in  3  rounding mode.
- in_zero  in  1  result is zero (zero or subnormal operand, no Inf/NaN).
- in_inf  in  1  result is infinity.
- in_nan  in  1  result is NaN (NaN operand, or Inf*0).
- out_valid  out  1  fp_Z valid.
- out_ready  in  1  downstream accepts.
- fp_Z  out  32  result.
- ovrf  out  1  overflow flag, aligned with fp_Z.
- udrf  out  1  underflow flag, aligned with fp_Z.
- nx  out  1  inexact flag, aligned with fp_Z.

Behaviour:
- Reset (async, rst_n=0): both stage valids=0, out_valid=0, fp_Z=0, ovrf=udrf=nx=0. Reset mid-operation drops in-flight items.
- Pipeline: S1 (normalize) -> S2 (round/pack), output registered at S2. Latency is 2 cycles from accepted input to out_valid. Full throughput of 1 item/cycle.
- Handshake:
  - A transfer occurs when valid&ready.
  - in_ready = !s1_v | (!s2_v | out_ready). Fully combinational stall chain, no bubbles.
  - While out_valid=1 and out_ready=0, fp_Z and flags hold stable.
  - Input fields are captured only on a transfer.
- S1 normalize:
  - If in_frc[47]: man=frc[46:24], g=frc[23], st=|frc[22:0], e=in_exp+1.
  - Else: man=frc[45:23], g=frc[22], st=|frc[21:0], e=in_exp.
  - Special flags, sign and rmode are pipelined alongside.
- S2 round, with inc decided by r_mode:
  - 000 RNE: g&(st|man[0]).
  - 001 RTZ: 0.
  - 010 RDN: sign&(g|st).
  - 011 RUP: !sign&(g|st).
  - 100 RMM: g.
  - 101-111: treated as RNE.
- Carry-out of the 24-bit {1,man}+inc sets man=0 and e=e+1.
- Priority: nan > inf > zero > underflow > overflow > normal.
- NaN: fp_Z=QNAN, flags 0.
- Inf: {sign,8'hFF,23'h0}, flags 0.
- Zero: {sign,31'h0}, flags 0.
- Underflow: pre-round e<=0 -> fp_Z={sign,31'h0}, udrf=1, nx=1.
- Overflow: post-round e>=255 -> ovrf=1, nx=1.
  - fp_Z={sign,8'hFF,0} for RNE/RMM, for RUP with sign=0, and for RDN with sign=1.
  - Otherwise fp_Z is max finite {sign,8'hFE,23'h7FFFFF}.
- Normal: fp_Z={sign,e[7:0],man}, nx=g|st.
- Arithmetic: exponent math is done in EXP_W+1 bits signed, so no wrap. Inputs and the +1 increment stay in range.

Optional Feature:
- Macro: FP_MUL_STICKY_FLAGS_EN.
- When defined, the block adds ports flags_clr (in, 1) and flags_sticky (out, 3, {ovrf,udrf,nx}).
- flags_sticky ORs in the flags of each output transfer (out_valid&out_ready).
- flags_clr=1 clears it synchronously; a transfer in the same cycle wins and its flags are recorded after the clear. Reset value is 0.
- When undefined, neither port exists and there is no sticky state.

Test Plan:
- in_frc=48'h900000000000 (1.5*1.5), in_exp=127, RNE -> 2 cycles later fp_Z=32'h40100000, flags 0.
- in_frc=48'h400000400000, in_exp=127 (exact tie, lsb 0):
  - RNE -> 32'h3F800000, nx=1.
  - RUP -> 32'h3F800001.
  - RMM -> 32'h3F800001.
  - RTZ -> 32'h3F800000.
- in_frc=48'h800000000000, in_exp=254:
  - RNE -> 32'h7F800000, ovrf=1, nx=1.
  - RTZ -> 32'h7F7FFFFF, ovrf=1.
- in_frc=48'h400000000000, in_exp=0, sign=1 -> 32'h80000000, udrf=1, nx=1.
- Specials:
  - in_nan=1 -> 32'h7FC00000.
  - in_inf=1, sign=1 -> 32'hFF800000.
  - in_zero=1, sign=1 -> 32'h80000000.
  - All three with flags 0.
- Backpressure: stream 4 back-to-back items with out_ready=0 for 3 cycles.
  - in_ready drops after 2 accepted items.
  - fp_Z stays stable while stalled.
  - All 4 emerge in order with no loss or duplication.
  - Assert rst_n low mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/fp_mul_norm_round.sv
// fp_mul_norm_round: normalize, round and pack stage of the fp32 multiplier.
// Optional macro FP_MUL_STICKY_FLAGS_EN adds flags_clr / flags_sticky.
module fp_mul_norm_round #(
    parameter int          EXP_W = 10,
    parameter logic [31:0] QNAN  = 32'h7FC00000
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef FP_MUL_STICKY_FLAGS_EN
    input  logic                    flags_clr,
    output logic [2:0]              flags_sticky,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic [47:0]             in_frc,
    input  logic [2:0]              in_rmode,
    input  logic                    in_zero,
    input  logic                    in_inf,
    input  logic                    in_nan,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             fp_Z,
    output logic                    ovrf,
    output logic                    udrf,
    output logic                    nx
);

    localparam int EW = EXP_W + 1;
    localparam logic signed [EW-1:0] L_EMAX = EW'(255);

    // S1 state
    logic                 r_s1_v;
    logic                 r_s1_sign;
    logic signed [EW-1:0] r_s1_e;
    logic [22:0]          r_s1_man;
    logic                 r_s1_g;
    logic                 r_s1_st;
    logic [2:0]           r_s1_rm;
    logic                 r_s1_zero;
    logic                 r_s1_inf;
    logic                 r_s1_nan;

    // S2 (output) state
    logic                 r_s2_v;
    logic [31:0]          r_fpz;
    logic                 r_ovrf;
    logic                 r_udrf;
    logic                 r_nx;

    logic                 w_s2_ready;
    logic                 w_load;
    logic signed [EW-1:0] w_exp_x;
    logic signed [EW-1:0] w_n_e;
    logic [22:0]          w_n_man;
    logic                 w_n_g;
    logic                 w_n_st;

    logic                 w_inc;
    logic                 w_carry;
    logic [22:0]          w_man_rnd;
    logic signed [EW-1:0] w_e_rnd;
    logic                 w_udf;
    logic                 w_ovf;
    logic                 w_ovf_inf;
    logic [31:0]          w_fpz;
    logic                 w_ovrf;
    logic                 w_udrf;
    logic                 w_nx;

    assign w_s2_ready = !r_s2_v | out_ready;
    assign in_ready   = !r_s1_v | w_s2_ready;
    assign w_load     = in_valid & in_ready;

    assign out_valid  = r_s2_v;
    assign fp_Z       = r_fpz;
    assign ovrf       = r_ovrf;
    assign udrf       = r_udrf;
    assign nx         = r_nx;

    // Normalize: a set bit 47 means the product is in [2,4)
    assign w_exp_x = {in_exp[EXP_W-1], in_exp};
    assign w_n_e   = w_exp_x + {{(EW-1){1'b0}}, in_frc[47]};
    assign w_n_man = in_frc[47] ? in_frc[46:24] : in_frc[45:23];
    assign w_n_g   = in_frc[47] ? in_frc[23] : in_frc[22];
    assign w_n_st  = in_frc[47] ? (|in_frc[22:0]) : (|in_frc[21:0]);

    // S1 register: captures a normalized item on every input transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_e    <= '0;
            r_s1_man  <= '0;
            r_s1_g    <= 1'b0;
            r_s1_st   <= 1'b0;
            r_s1_rm   <= '0;
            r_s1_zero <= 1'b0;
            r_s1_inf  <= 1'b0;
            r_s1_nan  <= 1'b0;
        end else if (in_ready) begin
            r_s1_v <= in_valid;
            if (w_load) begin
                r_s1_sign <= in_sign;
                r_s1_e    <= w_n_e;
                r_s1_man  <= w_n_man;
                r_s1_g    <= w_n_g;
                r_s1_st   <= w_n_st;
                r_s1_rm   <= in_rmode;
                r_s1_zero <= in_zero;
                r_s1_inf  <= in_inf;
                r_s1_nan  <= in_nan;
            end
        end
    end

    // Round-up decision; unused mode codes fall back to RNE
    always_comb begin
        w_inc = r_s1_g & (r_s1_st | r_s1_man[0]);
        case (r_s1_rm)
            3'b001:  w_inc = 1'b0;
            3'b010:  w_inc = r_s1_sign & (r_s1_g | r_s1_st);
            3'b011:  w_inc = !r_s1_sign & (r_s1_g | r_s1_st);
            3'b100:  w_inc = r_s1_g;
            default: w_inc = r_s1_g & (r_s1_st | r_s1_man[0]);
        endcase
    end

    // A carry out of the mantissa leaves it zero and bumps the exponent
    assign {w_carry, w_man_rnd} = {1'b0, r_s1_man} + {23'd0, w_inc};
    assign w_e_rnd = r_s1_e + {{(EW-1){1'b0}}, w_carry};
    assign w_udf   = r_s1_e[EW-1] | (r_s1_e == '0);
    assign w_ovf   = !w_e_rnd[EW-1] & (w_e_rnd >= L_EMAX);

    // Overflow saturates to max finite when rounding toward zero
    always_comb begin
        w_ovf_inf = 1'b1;
        case (r_s1_rm)
            3'b001:  w_ovf_inf = 1'b0;
            3'b010:  w_ovf_inf = r_s1_sign;
            3'b011:  w_ovf_inf = !r_s1_sign;
            default: w_ovf_inf = 1'b1;
        endcase
    end

    // Result select in priority order nan > inf > zero > udf > ovf
    always_comb begin
        w_fpz  = {r_s1_sign, w_e_rnd[7:0], w_man_rnd};
        w_ovrf = 1'b0;
        w_udrf = 1'b0;
        w_nx   = r_s1_g | r_s1_st;
        if (r_s1_nan) begin
            w_fpz = QNAN;
            w_nx  = 1'b0;
        end else if (r_s1_inf) begin
            w_fpz = {r_s1_sign, 8'hFF, 23'h0};
            w_nx  = 1'b0;
        end else if (r_s1_zero) begin
            w_fpz = {r_s1_sign, 31'h0};
            w_nx  = 1'b0;
        end else if (w_udf) begin
            w_fpz  = {r_s1_sign, 31'h0};
            w_udrf = 1'b1;
            w_nx   = 1'b1;
        end else if (w_ovf) begin
            w_fpz  = w_ovf_inf ? {r_s1_sign, 8'hFF, 23'h0}
                               : {r_s1_sign, 8'hFE, 23'h7FFFFF};
            w_ovrf = 1'b1;
            w_nx   = 1'b1;
        end
    end

    // S2 register: holds the packed result until downstream accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v <= 1'b0;
            r_fpz  <= '0;
            r_ovrf <= 1'b0;
            r_udrf <= 1'b0;
            r_nx   <= 1'b0;
        end else if (w_s2_ready) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_fpz  <= w_fpz;
                r_ovrf <= w_ovrf;
                r_udrf <= w_udrf;
                r_nx   <= w_nx;
            end
        end
    end

`ifdef FP_MUL_STICKY_FLAGS_EN
    logic [2:0] r_sticky;
    logic       w_out_xfer;

    assign w_out_xfer   = r_s2_v & out_ready;
    assign flags_sticky = r_sticky;

    // Accumulate flags of delivered results; a same-cycle transfer survives clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else if (flags_clr) begin
            r_sticky <= w_out_xfer ? {r_ovrf, r_udrf, r_nx} : 3'b000;
        end else if (w_out_xfer) begin
            r_sticky <= r_sticky | {r_ovrf, r_udrf, r_nx};
        end
    end
`endif

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Bench for fp_mul_norm_round: reference model, scoreboard, random traffic.
// Covers directed rounding cases, specials, backpressure and async reset.
module tb_fp_mul_norm_round;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic signed [9:0] in_exp;
    logic [47:0]       in_frc;
    logic [2:0]        in_rmode;
    logic              in_zero;
    logic              in_inf;
    logic              in_nan;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       fp_Z;
    logic              ovrf;
    logic              udrf;
    logic              nx;
`ifdef FP_MUL_STICKY_FLAGS_EN
    logic [2:0]        w_sticky;
`endif

    fp_mul_norm_round #(.EXP_W(10), .QNAN(32'h7FC00000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef FP_MUL_STICKY_FLAGS_EN
        .flags_clr   (1'b0),
        .flags_sticky(w_sticky),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_frc    (in_frc),
        .in_rmode  (in_rmode),
        .in_zero   (in_zero),
        .in_inf    (in_inf),
        .in_nan    (in_nan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp_Z      (fp_Z),
        .ovrf      (ovrf),
        .udrf      (udrf),
        .nx        (nx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [34:0] sb[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: exact quotient/remainder rounding of the raw product
    function automatic logic [34:0] model(input logic s, input int e,
        input logic [47:0] f, input logic [2:0] rm,
        input logic z, input logic i, input logic n);
        longint unsigned q, r, half;
        int sh, ee;
        logic up, exact, to_inf;
        if (n) return {32'h7FC00000, 3'b000};
        if (i) return {s, 8'hFF, 23'h0, 3'b000};
        if (z) return {s, 31'h0, 3'b000};
        sh = f[47] ? 24 : 23;
        q = {16'b0, f} >> sh;
        r = {16'b0, f} - (q << sh);
        half = 64'd1 << (sh - 1);
        ee = e + sh - 23;
        if (ee <= 0) return {s, 31'h0, 3'b011};
        exact = (r == 0);
        case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = s && !exact;
            3'd3:    up = !s && !exact;
            3'd4:    up = (r >= half);
            default: up = (r > half) || (r == half && q[0]);
        endcase
        q = q + 64'(up);
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            ee++;
        end
        if (ee >= 255) begin
            to_inf = !(rm == 3'd1 || (rm == 3'd2 && !s) || (rm == 3'd3 && s));
            return to_inf ? {s, 8'hFF, 23'h0, 3'b101}
                          : {s, 8'hFE, 23'h7FFFFF, 3'b101};
        end
        return {s, ee[7:0], q[22:0], 2'b00, !exact};
    endfunction

    // Scoreboard: pop on output transfer, push on input transfer
    logic        r_stall;
    logic [34:0] r_held;
    initial r_stall = 1'b0;
    always @(negedge clk) begin
        logic [34:0] got;
        got = {fp_Z, ovrf, udrf, nx};
        if (!rst_n) begin
            r_stall = 1'b0;
        end else begin
            if (r_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_hold", 64'(got), 64'(r_held));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 64'(got), 64'd0);
                    if (got == 35'd0) begin
                        n_err++;
                        $display("FAIL unexpected_out: got output, expected none");
                    end
                end else begin
                    chk("result", 64'(got), 64'(sb.pop_front()));
                end
            end
            r_stall = out_valid && !out_ready;
            r_held  = got;
            if (in_valid && in_ready)
                sb.push_back(model(in_sign, int'(in_exp), in_frc, in_rmode,
                                   in_zero, in_inf, in_nan));
        end
    end

    typedef struct {
        logic        s;
        int          e;
        logic [47:0] f;
        logic [2:0]  rm;
        logic        z;
        logic        i;
        logic        n;
        logic [34:0] req;
    } vec_t;
    vec_t tv[11];

    function automatic vec_t mk(input logic s, input int e,
        input logic [47:0] f, input logic [2:0] rm, input logic z,
        input logic i, input logic n, input logic [34:0] req);
        vec_t v;
        v.s = s; v.e = e; v.f = f; v.rm = rm;
        v.z = z; v.i = i; v.n = n; v.req = req;
        return v;
    endfunction

    task automatic set_in(input logic s, input int e, input logic [47:0] f,
        input logic [2:0] rm, input logic z, input logic i, input logic n);
        in_sign  = s;
        in_exp   = 10'(e);
        in_frc   = f;
        in_rmode = rm;
        in_zero  = z;
        in_inf   = i;
        in_nan   = n;
    endtask

    task automatic put(input vec_t v);
        int k;
        set_in(v.s, v.e, v.f, v.rm, v.z, v.i, v.n);
        in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("put_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic rand_in();
        logic [23:0] a, b;
        logic [47:0] f;
        int e;
        a = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
        b = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
        f = {24'b0, a} * {24'b0, b};
        case ($urandom_range(0, 5))
            0: f = f[47] ? {f[47:24], 24'h800000} : {f[47:23], 23'h400000};
            1: f = f[47] ? {24'hFFFFFF, f[23:0]} : {1'b0, 24'hFFFFFF, f[22:0]};
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: e = int'($urandom_range(0, 507)) - 126;
            1: e = int'($urandom_range(0, 4)) - 2;
            2: e = int'($urandom_range(252, 256));
            default: e = int'($urandom_range(1, 253));
        endcase
        set_in(1'($urandom_range(0, 1)), e, f, 3'($urandom_range(0, 7)),
               $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 15) == 0);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1 chk(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_in(1'b0, 0, 48'h0, 3'd0, 1'b0, 1'b0, 1'b0);

        tv[0]  = mk(0, 127, 48'h900000000000, 3'd0, 0, 0, 0, {32'h40100000, 3'b000});
        tv[1]  = mk(0, 127, 48'h400000400000, 3'd0, 0, 0, 0, {32'h3F800000, 3'b001});
        tv[2]  = mk(0, 127, 48'h400000400000, 3'd3, 0, 0, 0, {32'h3F800001, 3'b001});
        tv[3]  = mk(0, 127, 48'h400000400000, 3'd4, 0, 0, 0, {32'h3F800001, 3'b001});
        tv[4]  = mk(0, 127, 48'h400000400000, 3'd1, 0, 0, 0, {32'h3F800000, 3'b001});
        tv[5]  = mk(0, 254, 48'h800000000000, 3'd0, 0, 0, 0, {32'h7F800000, 3'b101});
        tv[6]  = mk(0, 254, 48'h800000000000, 3'd1, 0, 0, 0, {32'h7F7FFFFF, 3'b101});
        tv[7]  = mk(1, 0,   48'h400000000000, 3'd0, 0, 0, 0, {32'h80000000, 3'b011});
        tv[8]  = mk(0, 127, 48'h800000000000, 3'd0, 0, 0, 1, {32'h7FC00000, 3'b000});
        tv[9]  = mk(1, 127, 48'h800000000000, 3'd0, 0, 1, 0, {32'hFF800000, 3'b000});
        tv[10] = mk(1, 127, 48'h800000000000, 3'd0, 1, 0, 0, {32'h80000000, 3'b000});

        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fp_Z", 64'(fp_Z), 64'd0);
        chk("rst_flags", 64'({ovrf, udrf, nx}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (tv[k])
            chk($sformatf("model_pin_%0d", k),
                64'(model(tv[k].s, tv[k].e, tv[k].f, tv[k].rm,
                          tv[k].z, tv[k].i, tv[k].n)),
                64'(tv[k].req));

        foreach (tv[k]) put(tv[k]);
        drain("drain_directed");

        // back-to-back with a stalled sink
        @(posedge clk);
        #1 out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            put_hold_bp: begin
                set_in(1'b0, 100 + idx, 48'h900000000000 + 48'(idx), 3'd0,
                       1'b0, 1'b0, 1'b0);
                in_valid = 1'b1;
            end
            @(negedge clk);
            if (c >= 2) chk("bp_in_ready_drop", 64'(in_ready), 64'd0);
            if (in_ready) idx++;
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", 64'(idx), 64'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && idx < 4; k++) begin
            set_in(1'b0, 100 + idx, 48'h900000000000 + 48'(idx), 3'd0,
                   1'b0, 1'b0, 1'b0);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", 64'(idx), 64'd4);
        drain("drain_bp");

        // random traffic with random backpressure
        for (int c = 0; c < 600; c++) begin
            rand_in();
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("drain_random");

        // reset in the middle of a stream
        for (int c = 0; c < 3; c++) begin
            rand_in();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_fp_Z", 64'(fp_Z), 64'd0);
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        put(tv[0]);
        drain("drain_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
